// File: rtl/pic_irq_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pic_irq_sequencer
// Brief    : 8259-style priority resolver, INTA handshake, ISR and rotation.
// Revision : 1.0
// ============================================================================
module pic_irq_sequencer #(
  parameter int NUM_IR      = 8,
  parameter int SPURIOUS_IR = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_IR-1:0] irr_i,
  input  logic [NUM_IR-1:0] imr_i,
  input  logic              inta_stb_i,
  input  logic              eoi_stb_i,
  input  logic [2:0]        eoi_cmd_i,
  input  logic [2:0]        eoi_lvl_i,
  input  logic              aeoi_i,
  input  logic [4:0]        vec_base_i,
  output logic              int_out_o,
  output logic [NUM_IR-1:0] irr_clr_o,
  output logic [NUM_IR-1:0] isr_o,
  output logic [7:0]        vec_out_o,
  output logic              vec_oe_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_ACK1 = 2'd2,
    ST_ACK2 = 2'd3
  } state_t;

  localparam logic [2:0] C_CMD_NSEOI = 3'b001;
  localparam logic [2:0] C_CMD_SEOI  = 3'b011;
  localparam logic [2:0] C_CMD_RNS   = 3'b101;
  localparam logic [2:0] C_CMD_RSP   = 3'b111;
  localparam logic [2:0] C_CMD_SETP  = 3'b110;

  state_t            state_q;
  logic [2:0]        low_pri_q, low_pri_d;
  logic [NUM_IR-1:0] isr_q, isr_d;
  logic [NUM_IR-1:0] irr_clr_q;
  logic [2:0]        lvl_q;
  logic              spur_q;
  logic              int_q;
  logic [7:0]        vec_q;
  logic              vec_oe_q;

  logic [3:0]        w_cand;
  logic [3:0]        w_blk;
  logic              w_valid;

  // Returns {found, index} of the highest-priority set bit; scanning from
  // lowest to highest priority lets the last hit win.
  function automatic logic [3:0] pick_hi(input logic [7:0] v, input logic [2:0] lp);
    logic [3:0] r;
    logic [2:0] idx;
    r = 4'd0;
    for (int k = 8; k >= 1; k--) begin
      idx = lp + 3'(k);
      if (v[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

  // 0 = highest priority, 7 = lowest (the low_pri level itself)
  function automatic logic [2:0] rank(input logic [2:0] idx, input logic [2:0] lp);
    return idx - lp - 3'd1;
  endfunction

  always_comb begin
    w_cand  = pick_hi(irr_i & ~imr_i, low_pri_q);
    w_blk   = pick_hi(isr_q, low_pri_q);
    w_valid = w_cand[3] &&
              ((isr_q == '0) || (rank(w_cand[2:0], low_pri_q) < rank(w_blk[2:0], low_pri_q)));
  end

  // EOI clear is applied before the INTA #1 set; candidate uses pre-EOI isr.
  always_comb begin
    isr_d     = isr_q;
    low_pri_d = low_pri_q;
    if (eoi_stb_i) begin
      case (eoi_cmd_i)
        C_CMD_NSEOI: if (w_blk[3]) isr_d[w_blk[2:0]] = 1'b0;
        C_CMD_SEOI:  isr_d[eoi_lvl_i] = 1'b0;
        C_CMD_RNS: begin
          if (w_blk[3]) begin
            isr_d[w_blk[2:0]] = 1'b0;
            low_pri_d         = w_blk[2:0];
          end
        end
        C_CMD_RSP: begin
          if (isr_q != '0) begin
            isr_d[eoi_lvl_i] = 1'b0;
            low_pri_d        = eoi_lvl_i;
          end
        end
        C_CMD_SETP: low_pri_d = eoi_lvl_i;
        default: ;
      endcase
    end
    if ((state_q == ST_REQ) && inta_stb_i && w_valid) isr_d[w_cand[2:0]] = 1'b1;
    if ((state_q == ST_ACK2) && aeoi_i && !spur_q) isr_d[lvl_q] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      low_pri_q <= 3'd7;
      isr_q     <= '0;
      irr_clr_q <= '0;
      lvl_q     <= 3'd0;
      spur_q    <= 1'b0;
      int_q     <= 1'b0;
      vec_q     <= 8'd0;
      vec_oe_q  <= 1'b0;
    end else begin
      isr_q     <= isr_d;
      low_pri_q <= low_pri_d;
      irr_clr_q <= '0;
      vec_oe_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (w_valid) begin
            int_q   <= 1'b1;
            state_q <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (inta_stb_i) begin
            int_q   <= 1'b0;
            state_q <= ST_ACK1;
            if (w_valid) begin
              lvl_q                  <= w_cand[2:0];
              spur_q                 <= 1'b0;
              irr_clr_q[w_cand[2:0]] <= 1'b1;
            end else begin
              lvl_q  <= 3'(SPURIOUS_IR);
              spur_q <= 1'b1;
            end
          end else if (!w_valid) begin
            int_q   <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_ACK1: begin
          int_q <= 1'b0;
          if (inta_stb_i) begin
            vec_q    <= {vec_base_i, lvl_q};
            vec_oe_q <= 1'b1;
            state_q  <= ST_ACK2;
          end
        end
        ST_ACK2: begin
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign int_out_o = int_q;
  assign irr_clr_o = irr_clr_q;
  assign isr_o     = isr_q;
  assign vec_out_o = vec_q;
  assign vec_oe_o  = vec_oe_q;

endmodule
`default_nettype wire
